// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin arbiter sharing one sprite ROM read port
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 13,
   parameter int DATA_W  = 2,
   parameter int ROM_LAT = 1,
   parameter int PRIO0   = 0
) (
   input  logic                      vga_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [DATA_W-1:0]         rom_q,
   output logic [NUM_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      idle
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0]                rr_ptr;
   logic [IDX_W-1:0]                win;
   logic                            win_rr;
   logic                            any_gnt;
   logic [ROM_LAT-1:0]              tag_v;
   logic [ROM_LAT-1:0][IDX_W-1:0]   tag_w;

   // Requester 0 may pre-empt the rotation; otherwise scan from rr_ptr upward.
   always_comb begin
      gnt     = '0;
      win     = '0;
      win_rr  = 1'b0;
      any_gnt = 1'b0;
      if (PRIO0 != 0 && req[0]) begin
         gnt[0]  = 1'b1;
         any_gnt = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_gnt && req[idx]) begin
               gnt[idx] = 1'b1;
               win      = IDX_W'(idx);
               win_rr   = 1'b1;
               any_gnt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rr_ptr      <= '0;
         rom_address <= '0;
         tag_v       <= '0;
         tag_w       <= '0;
         rd_valid    <= '0;
         rd_data     <= '0;
      end else begin
         if (win_rr)
            rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
         if (any_gnt)
            rom_address <= req_addr[int'(win)*ADDR_W +: ADDR_W];
         tag_v[0] <= any_gnt;
         tag_w[0] <= win;
         for (int k = 1; k < ROM_LAT; k++) begin
            tag_v[k] <= tag_v[k-1];
            tag_w[k] <= tag_w[k-1];
         end
         // The last tag stage lines up with the ROM output for that address.
         if (tag_v[ROM_LAT-1]) begin
            rd_data  <= rom_q;
            rd_valid <= NUM_REQ'(1) << tag_w[ROM_LAT-1];
         end else begin
            rd_valid <= '0;
         end
      end
   end

   assign idle = (req == '0) && (tag_v == '0);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 13;
   localparam int DW = 2;

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 vga_clk = ~vga_clk;

   // u0: pure RR, ROM_LAT=1
   logic [N-1:0] req0 = '0, gnt0, rv0;
   logic [N*AW-1:0] addr0 = '0;
   logic [AW-1:0] ra0;
   logic [DW-1:0] q0 = '0, rd0;
   logic idle0;
   // u1: PRIO0=1, ROM_LAT=1
   logic [N-1:0] req1 = '0, gnt1, rv1;
   logic [N*AW-1:0] addr1 = '0;
   logic [AW-1:0] ra1;
   logic [DW-1:0] q1 = '0, rd1;
   logic idle1;
   // u2: pure RR, ROM_LAT=3
   logic [N-1:0] req2 = '0, gnt2, rv2;
   logic [N*AW-1:0] addr2 = '0;
   logic [AW-1:0] ra2;
   logic [DW-1:0] rd2;
   logic idle2;
   logic [AW-1:0] p2 [3];

   int n_cmp = 0;
   int n_err = 0;

   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(0)) u0 (
      .vga_clk(vga_clk), .reset(reset), .req(req0), .req_addr(addr0), .gnt(gnt0),
      .rom_address(ra0), .rom_q(q0), .rd_valid(rv0), .rd_data(rd0), .idle(idle0));
   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(1)) u1 (
      .vga_clk(vga_clk), .reset(reset), .req(req1), .req_addr(addr1), .gnt(gnt1),
      .rom_address(ra1), .rom_q(q1), .rd_valid(rv1), .rd_data(rd1), .idle(idle1));
   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .PRIO0(0)) u2 (
      .vga_clk(vga_clk), .reset(reset), .req(req2), .req_addr(addr2), .gnt(gnt2),
      .rom_address(ra2), .rom_q(rom_f(p2[2])), .rd_valid(rv2), .rd_data(rd2), .idle(idle2));

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[1:0] ^ a[3:2] ^ a[5:4];
   endfunction

   // ROM models: read on negedge, address pipelined to give the requested latency
   always @(negedge vga_clk) begin
      q0 <= rom_f(ra0);
      q1 <= rom_f(ra1);
      p2[0] <= ra2;
      p2[1] <= p2[0];
      p2[2] <= p2[1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [AW-1:0] a_rr [N];
   logic [AW-1:0] a_hold;

   initial begin
      for (int i = 0; i < N; i++) p2[i % 3] = '0;
      tick();
      tick();
      chk("reset_rv", 32'(rv0), 32'h0);
      chk("reset_rd", 32'(rd0), 32'h0);
      chk("reset_ra", 32'(ra0), 32'h0);
      chk("reset_idle", 32'(idle0), 32'h1);
      chk("reset_gnt", 32'(gnt0), 32'h0);
      reset = 1'b0;
      tick();

      // single request from requester 2; other slices hold ignored junk
      for (int i = 0; i < N; i++) addr0[i*AW +: AW] = 13'h1FFF;
      addr0[2*AW +: AW] = 13'h0A5;
      req0 = 4'b0100;
      #1;
      chk("single_gnt", 32'(gnt0), 32'h4);
      chk("single_idle_busy", 32'(idle0), 32'h0);
      tick();
      req0 = 4'b0000;
      chk("single_ra", 32'(ra0), 32'h0A5);
      chk("single_rv_early", 32'(rv0), 32'h0);
      tick();
      chk("single_rv", 32'(rv0), 32'h4);
      chk("single_rd", 32'(rd0), 32'(rom_f(13'h0A5)));
      chk("single_idle", 32'(idle0), 32'h1);
      tick();
      chk("single_rv_clear", 32'(rv0), 32'h0);

      // all four requesting: grants rotate 0,1,2,3 twice
      do_reset();
      a_rr[0] = 13'h001; a_rr[1] = 13'h006; a_rr[2] = 13'h01B; a_rr[3] = 13'h02C;
      for (int i = 0; i < N; i++) addr0[i*AW +: AW] = a_rr[i];
      req0 = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr_gnt", 32'(gnt0), 32'(4'b0001 << (c % 4)));
         tick();
         chk("rr_ra", 32'(ra0), 32'(a_rr[c % 4]));
         if (c >= 1) begin
            chk("rr_rv", 32'(rv0), 32'(4'b0001 << ((c - 1) % 4)));
            chk("rr_rd", 32'(rd0), 32'(rom_f(a_rr[(c - 1) % 4])));
         end
      end
      req0 = 4'b0000;
      tick();
      chk("rr_rv_last", 32'(rv0), 32'h8);
      chk("rr_rd_last", 32'(rd0), 32'(rom_f(a_rr[3])));

      // reset with reads in flight: outputs clear at once, nothing after release
      req0 = 4'b0011;
      tick();
      tick();
      chk("inflight_rv_pre", 32'(rv0), 32'h1);
      reset = 1'b1;
      req0 = 4'b0000;
      #1;
      chk("inflight_rv_async", 32'(rv0), 32'h0);
      chk("inflight_rd_async", 32'(rd0), 32'h0);
      chk("inflight_ra_async", 32'(ra0), 32'h0);
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("inflight_no_rv", 32'(rv0), 32'h0);
      end

      // idle cycles: address holds, no grants, no returns
      a_hold = 13'h1ABC;
      addr0[3*AW +: AW] = a_hold;
      req0 = 4'b1000;
      #1;
      chk("hold_gnt", 32'(gnt0), 32'h8);
      tick();
      req0 = 4'b0000;
      tick();
      chk("hold_rv", 32'(rv0), 32'h8);
      chk("hold_rd", 32'(rd0), 32'(rom_f(a_hold)));
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("hold_gnt0", 32'(gnt0), 32'h0);
         chk("hold_rv0", 32'(rv0), 32'h0);
         chk("hold_ra", 32'(ra0), 32'(a_hold));
         chk("hold_idle", 32'(idle0), 32'h1);
      end

      // absolute priority for requester 0
      do_reset();
      addr1[0*AW +: AW] = 13'h011;
      addr1[1*AW +: AW] = 13'h022;
      addr1[3*AW +: AW] = 13'h033;
      req1 = 4'b1011;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("prio_gnt0", 32'(gnt1), 32'h1);
         tick();
      end
      chk("prio_rd", 32'(rd1), 32'(rom_f(13'h011)));
      req1 = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("prio_alt", 32'(gnt1), (c % 2 == 0) ? 32'h2 : 32'h8);
         tick();
      end
      req1 = 4'b0000;
      tick();
      chk("prio_rv_last", 32'(rv1), 32'h8);
      chk("prio_rd_last", 32'(rd1), 32'(rom_f(13'h033)));

      // ROM_LAT=3: back-to-back grants to 1 then 3
      do_reset();
      addr2[1*AW +: AW] = 13'h027;
      addr2[3*AW +: AW] = 13'h038;
      req2 = 4'b0010;
      #1;
      chk("lat3_gnt1", 32'(gnt2), 32'h2);
      tick();
      req2 = 4'b1000;
      #1;
      chk("lat3_gnt3", 32'(gnt2), 32'h8);
      tick();
      req2 = 4'b0000;
      chk("lat3_rv_e2", 32'(rv2), 32'h0);
      tick();
      chk("lat3_rv_e3", 32'(rv2), 32'h0);
      chk("lat3_idle_busy", 32'(idle2), 32'h0);
      tick();
      chk("lat3_rv_a", 32'(rv2), 32'h2);
      chk("lat3_rd_a", 32'(rd2), 32'(rom_f(13'h027)));
      tick();
      chk("lat3_rv_b", 32'(rv2), 32'h8);
      chk("lat3_rd_b", 32'(rd2), 32'(rom_f(13'h038)));
      chk("lat3_idle", 32'(idle2), 32'h1);
      tick();
      chk("lat3_rv_clear", 32'(rv2), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
